// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the multi-cycle MIPS control path:
//               FSM states, opcode/funct values, and datapath select codes
//               (ALUctr, PCSrc, RegDst, MemtoReg, EXTOp). Also provides the
//               DECODE dispatch function.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_ori   = 6'h0d;
  localparam logic [5:0] c_op_lui   = 6'h0f;
  localparam logic [5:0] c_op_lh    = 6'h21;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sb    = 6'h28;
  localparam logic [5:0] c_op_sw    = 6'h2b;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] c_fn_sll  = 6'h00;
  localparam logic [5:0] c_fn_jr   = 6'h08;
  localparam logic [5:0] c_fn_addu = 6'h21;
  localparam logic [5:0] c_fn_subu = 6'h23;
  localparam logic [5:0] c_fn_and  = 6'h24;
  localparam logic [5:0] c_fn_or   = 6'h25;
  localparam logic [5:0] c_fn_slt  = 6'h2a;

  // ALU operation select
  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b100;
  localparam logic [2:0] c_alu_sll = 3'b101;

  // Next-PC select
  localparam logic [1:0] c_pc_plus4  = 2'b00;
  localparam logic [1:0] c_pc_branch = 2'b01;
  localparam logic [1:0] c_pc_jump   = 2'b10;
  localparam logic [1:0] c_pc_jr     = 2'b11;

  // Destination register select
  localparam logic [1:0] c_rd_rt = 2'b00;
  localparam logic [1:0] c_rd_rd = 2'b01;
  localparam logic [1:0] c_rd_ra = 2'b10;

  // Register write-back source select
  localparam logic [1:0] c_m2r_alu = 2'b00;
  localparam logic [1:0] c_m2r_mdr = 2'b01;
  localparam logic [1:0] c_m2r_pc4 = 2'b10;

  // Immediate extension mode
  localparam logic [1:0] c_ext_zero = 2'b00;
  localparam logic [1:0] c_ext_sign = 2'b01;
  localparam logic [1:0] c_ext_lui  = 2'b10;

  // DECODE dispatch: anything not recognised goes to TRAP.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t r;
    r = S_TRAP;
    case (op)
      c_op_lw, c_op_lh, c_op_sw, c_op_sb: r = S_MEMADR;
      c_op_ori, c_op_lui:                 r = S_EXEC;
      c_op_beq:                           r = S_BRANCH;
      c_op_j, c_op_jal:                   r = S_JUMP;
      c_op_rtype: begin
        case (fn)
          c_fn_addu, c_fn_subu, c_fn_and,
          c_fn_or, c_fn_slt, c_fn_sll:    r = S_EXEC;
          c_fn_jr:                        r = S_JUMP;
          default:                        r = S_TRAP;
        endcase
      end
      default:                            r = S_TRAP;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Memory handshake bundle between the controller (master) and
//               the variable-latency memory (slave).
//               mem_req   - access request
//               mem_ready - access done (only meaningful while mem_req=1)
//               IorD      - address source, 0 PC / 1 ALUOut
//               MemWr     - write strobe
//               sb, lh    - byte-store / signed-half-load qualifiers
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic IorD;
  logic MemWr;
  logic sb;
  logic lh;

  modport master (output mem_req, IorD, MemWr, sb, lh, input mem_ready);
  modport slave  (input mem_req, IorD, MemWr, sb, lh, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
// Module      : mc_aludec
// Description : Combinational ALU decoder for the multi-cycle controller.
//               Ports: opcode, funct, state in; ALUctr (3b), ALUSrc1 out.
//               Selects the R-type/I-type operation in EXEC and subtract in
//               BRANCH; every other state uses add (PC+4, address, target).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_aludec
  import ctrl_pkg::*;
(
  input  wire logic [5:0] opcode,
  input  wire logic [5:0] funct,
  input  wire state_t     state,
  output logic      [2:0] ALUctr,
  output logic            ALUSrc1
);

  always_comb begin
    ALUctr  = c_alu_add;
    ALUSrc1 = 1'b0;
    case (state)
      S_EXEC: begin
        if (opcode == c_op_rtype) begin
          case (funct)
            c_fn_subu: ALUctr = c_alu_sub;
            c_fn_and:  ALUctr = c_alu_and;
            c_fn_or:   ALUctr = c_alu_or;
            c_fn_slt:  ALUctr = c_alu_slt;
            c_fn_sll: begin
              ALUctr  = c_alu_sll;
              ALUSrc1 = 1'b1;  // shift amount comes from shamt, not rs
            end
            default:   ALUctr = c_alu_add;
          endcase
        end else if (opcode == c_op_ori) begin
          ALUctr = c_alu_or;
        end
        // lui: rs is $0, so add passes the shifted immediate through
      end
      S_BRANCH: ALUctr = c_alu_sub;
      default:  ALUctr = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
//               Ports: clk, rst_n (async, active low); opcode, funct, zero
//               from IR/ALU; mem (memory handshake, master side); write
//               enables IRWr/PCWr/RegWr; selects RegDst, MemtoReg, PCSrc,
//               ALUSrc, ALUSrc1, EXTOp, ALUctr; status instr_done, trap,
//               bus_err. Memory waits are bounded by WAIT_MAX cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit MEM_HS   = 1'b1,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  wire logic [0:0]  clk,
  input  wire logic        rst_n,
  input  wire logic [5:0]  opcode,
  input  wire logic [5:0]  funct,
  input  wire logic        zero,
  multicycle_controller_if.master mem,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       PCSrc,
  output logic             ALUSrc,
  output logic             ALUSrc1,
  output logic [1:0]       EXTOp,
  output logic [2:0]       ALUctr,
  output logic             instr_done,
  output logic             trap,
  output logic             bus_err
);

  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(WAIT_MAX - 1);

  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_mem_state, w_ready, w_timeout;
  logic              w_mem_req, w_iord, w_memwr, w_sb, w_lh;
  logic              w_irwr, w_pcwr, w_regwr, w_alusrc, w_alusrc1;
  logic              w_done, w_trap, w_bus_err;
  logic [1:0]        w_regdst, w_memtoreg, w_pcsrc, w_extop;
  logic [2:0]        w_aluctr;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  // The timeout fires on the WAIT_MAX-th consecutive cycle without ready;
  // ready on that same cycle takes priority.
  generate
    if (MEM_HS) begin : g_hs
      assign w_ready   = mem.mem_ready;
      assign w_timeout = w_mem_state && !mem.mem_ready && (r_wait_cnt == c_wait_last);
    end else begin : g_no_hs
      assign w_ready   = 1'b1;
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Clearing on any state change (and on timeout, which may re-enter FETCH)
  // gives every memory state a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!MEM_HS || (w_next != r_state) || w_timeout) begin
      r_wait_cnt <= '0;
    end else if (w_mem_state) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_mem_req  = 1'b0;
    w_iord     = 1'b0;
    w_memwr    = 1'b0;
    w_sb       = 1'b0;
    w_lh       = 1'b0;
    w_irwr     = 1'b0;
    w_pcwr     = 1'b0;
    w_regwr    = 1'b0;
    w_alusrc   = 1'b0;
    w_regdst   = c_rd_rt;
    w_memtoreg = c_m2r_alu;
    w_pcsrc    = c_pc_plus4;
    w_extop    = c_ext_zero;
    w_done     = 1'b0;
    w_trap     = 1'b0;
    w_bus_err  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (w_timeout) begin
          w_trap    = 1'b1;
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end else if (w_ready) begin
          w_irwr  = 1'b1;
          w_pcwr  = 1'b1;
          w_pcsrc = c_pc_plus4;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target PC+4+(simm<<2) into ALUOut
        w_alusrc = 1'b1;
        w_extop  = c_ext_sign;
        w_next   = decode_next(opcode, funct);
      end
      S_MEMADR: begin
        w_alusrc = 1'b1;
        w_extop  = c_ext_sign;
        w_next   = ((opcode == c_op_lw) || (opcode == c_op_lh)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_lh      = (opcode == c_op_lh);
        if (w_timeout) begin
          w_trap    = 1'b1;
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end else if (w_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_regwr    = 1'b1;
        w_regdst   = c_rd_rt;
        w_memtoreg = c_m2r_mdr;
        w_lh       = (opcode == c_op_lh);
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_sb      = (opcode == c_op_sb);
        if (w_timeout) begin
          w_trap    = 1'b1;
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_memwr = 1'b1;
          if (w_ready) begin
            w_done = 1'b1;
            w_next = S_FETCH;
          end
        end
      end
      S_EXEC: begin
        w_alusrc = (opcode != c_op_rtype);
        w_extop  = (opcode == c_op_lui) ? c_ext_lui : c_ext_zero;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwr    = 1'b1;
        w_regdst   = (opcode == c_op_rtype) ? c_rd_rd : c_rd_rt;
        w_memtoreg = c_m2r_alu;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_pcsrc = c_pc_branch;
        w_pcwr  = zero;
        w_done  = 1'b1;
        w_next  = S_FETCH;
      end
      S_JUMP: begin
        w_pcwr  = 1'b1;
        w_pcsrc = (opcode == c_op_rtype) ? c_pc_jr : c_pc_jump;
        if (opcode == c_op_jal) begin
          w_regwr    = 1'b1;
          w_regdst   = c_rd_ra;
          w_memtoreg = c_m2r_pc4;
        end
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        w_trap = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .opcode  (opcode),
    .funct   (funct),
    .state   (r_state),
    .ALUctr  (w_aluctr),
    .ALUSrc1 (w_alusrc1)
  );

  // State decode alone would show FETCH controls during reset; masking with
  // rst_n forces every output low for as long as reset is held.
  assign mem.mem_req = rst_n & w_mem_req;
  assign mem.IorD    = rst_n & w_iord;
  assign mem.MemWr   = rst_n & w_memwr;
  assign mem.sb      = rst_n & w_sb;
  assign mem.lh      = rst_n & w_lh;
  assign IRWr        = rst_n & w_irwr;
  assign PCWr        = rst_n & w_pcwr;
  assign RegWr       = rst_n & w_regwr;
  assign ALUSrc      = rst_n & w_alusrc;
  assign ALUSrc1     = rst_n & w_alusrc1;
  assign RegDst      = {2{rst_n}} & w_regdst;
  assign MemtoReg    = {2{rst_n}} & w_memtoreg;
  assign PCSrc       = {2{rst_n}} & w_pcsrc;
  assign EXTOp       = {2{rst_n}} & w_extop;
  assign ALUctr      = {3{rst_n}} & w_aluctr;
  assign instr_done  = rst_n & w_done;
  assign trap        = rst_n & w_trap;
  assign bus_err     = rst_n & w_bus_err;

endmodule
`default_nettype wire
